// File: rtl/prefetch_dma_responder.sv
// Prefetch DMA responder: splits one line request into word reads and reassembles the line.
// Optional macro PREFETCH_DMA_RESPONDER_DEMAND_PREEMPT_EN pauses word issue while demand owns memory.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   e_idle  | waiting for a prefetch request
//   e_fill  | issuing word reads and collecting responses
//   e_done  | one-cycle line valid pulse
module prefetch_dma_responder #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic                                          prefetch_dma_req_i,
  input  logic [addr_width_p-1:0]                       prefetch_dma_addr_i,
  input  logic                                          demand_busy_i,
  output logic                                          dma_busy_o,
  output logic                                          mem_req_v_o,
  output logic [addr_width_p-1:0]                       mem_req_addr_o,
  input  logic                                          mem_req_ready_i,
  input  logic                                          mem_resp_v_i,
  input  logic [data_width_p-1:0]                       mem_resp_data_i,
  output logic [data_width_p*block_size_in_words_p-1:0] dma_prefetch_data_o,
  output logic                                          dma_prefetch_data_v_o
);

  localparam int bytes_lp  = data_width_p / 8;
  localparam int loff_lp   = $clog2(block_size_in_words_p * bytes_lp);
  localparam int cnt_w_lp  = $clog2(block_size_in_words_p) + 1;
  localparam int line_w_lp = data_width_p * block_size_in_words_p;
  localparam logic [cnt_w_lp-1:0] words_lp = cnt_w_lp'(block_size_in_words_p);

  typedef enum logic [1:0] {e_idle, e_fill, e_done} state_e;

  state_e                  state_r, state_n;
  logic [addr_width_p-1:0] base_r;
  logic [cnt_w_lp-1:0]     issue_cnt_r, resp_cnt_r;
  logic [line_w_lp-1:0]    line_r;
  logic                    accept, issue_fire, resp_fire, preempt;

`ifdef PREFETCH_DMA_RESPONDER_DEMAND_PREEMPT_EN
  assign preempt = demand_busy_i;
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n               = state_r;
    accept                = 1'b0;
    resp_fire             = 1'b0;
    mem_req_v_o           = 1'b0;
    mem_req_addr_o        = '0;
    dma_prefetch_data_v_o = 1'b0;
    case (state_r)
      e_idle: begin
        if (prefetch_dma_req_i && !demand_busy_i) begin
          accept  = 1'b1;
          state_n = e_fill;
        end
      end
      e_fill: begin
        mem_req_v_o = (issue_cnt_r < words_lp) && !preempt;
        if (mem_req_v_o)
          mem_req_addr_o = base_r + addr_width_p'(issue_cnt_r) * addr_width_p'(bytes_lp);
        resp_fire = mem_resp_v_i && (resp_cnt_r < words_lp);
        // leave on the edge that captures the last word so the pulse lands at B+2
        if (resp_fire && (resp_cnt_r == words_lp - 1'b1))
          state_n = e_done;
      end
      e_done: begin
        dma_prefetch_data_v_o = 1'b1;
        state_n               = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign issue_fire          = mem_req_v_o && mem_req_ready_i;
  assign dma_busy_o          = (state_r != e_idle) || demand_busy_i;
  assign dma_prefetch_data_o = line_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_idle;
      base_r      <= '0;
      issue_cnt_r <= '0;
      resp_cnt_r  <= '0;
      line_r      <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        base_r      <= (prefetch_dma_addr_i >> loff_lp) << loff_lp;
        issue_cnt_r <= '0;
        resp_cnt_r  <= '0;
      end else begin
        if (issue_fire) issue_cnt_r <= issue_cnt_r + 1'b1;
        if (resp_fire) begin
          resp_cnt_r <= resp_cnt_r + 1'b1;
          for (int i = 0; i < block_size_in_words_p; i++)
            if (resp_cnt_r == cnt_w_lp'(i))
              line_r[i*data_width_p +: data_width_p] <= mem_resp_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_dma_responder.sv
// Directed bench for prefetch_dma_responder: per-cycle vector table plus fill sequences
// with a small in-order memory responder for backpressure, wrap and preemption.
module tb_prefetch_dma_responder;

  localparam logic [255:0] LINE_0 = 256'h0;
  localparam logic [255:0] LINE_A = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};

  logic         clk_i = 1'b0;
  logic         reset_n_i, req, demand, ready, resp_v;
  logic [31:0]  addr, resp_data;
  logic         busy, mv, dv;
  logic [31:0]  maddr;
  logic [255:0] line;

  int n_vec = 0;
  int n_err = 0;

  prefetch_dma_responder dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .prefetch_dma_req_i    (req),
    .prefetch_dma_addr_i   (addr),
    .demand_busy_i         (demand),
    .dma_busy_o            (busy),
    .mem_req_v_o           (mv),
    .mem_req_addr_o        (maddr),
    .mem_req_ready_i       (ready),
    .mem_resp_v_i          (resp_v),
    .mem_resp_data_i       (resp_data),
    .dma_prefetch_data_o   (line),
    .dma_prefetch_data_v_o (dv)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         rst_n, req;
    logic [31:0]  addr;
    logic         dem, rdy, rv;
    logic [31:0]  data;
    logic         busy, v;
    logic [31:0]  ma;
    logic         dv, chk_line;
    logic [255:0] line;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int rst_n, int rq, logic [31:0] a, int dm, int rdy, int rv,
                              logic [31:0] d, int bz, int v, logic [31:0] ma, int pv,
                              int cl, logic [255:0] ln);
    vec_t t;
    t.rst_n = (rst_n != 0); t.req = (rq != 0); t.addr = a; t.dem = (dm != 0);
    t.rdy = (rdy != 0); t.rv = (rv != 0); t.data = d; t.busy = (bz != 0);
    t.v = (v != 0); t.ma = ma; t.dv = (pv != 0); t.chk_line = (cl != 0); t.line = ln;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one line fill from IDLE; the responder answers each handshake one cycle later.
  // pre_at >= 0 raises demand_busy_i for 5 cycles once that many words have been issued.
  task automatic run_fill(string tag, logic [31:0] start, logic [31:0] base, bit toggle,
                          logic [31:0] seed, int pre_at);
    int hs = 0, rcv = 0, last_rcv = -10, win = 0;
    bit pend = 1'b0, got = 1'b0, dem;
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = seed + 32'(i);
    @(negedge clk_i);
    req = 1'b1; addr = start; ready = 1'b0; resp_v = 1'b0; demand = 1'b0;
    #1 chk({tag, "_idle_busy"}, 256'(busy), 256'(1'b0));
    @(negedge clk_i);
    req = 1'b0; addr = '0;
    for (int cyc = 0; cyc < 80 && !got; cyc++) begin
      dem = (pre_at >= 0) && (hs == pre_at) && (win < 5);
      if (dem) win++;
      demand    = dem;
      ready     = toggle ? (cyc % 2 == 1) : 1'b1;
      resp_v    = pend;
      resp_data = seed + 32'(rcv);
      #1;
      if (dv) begin
        chk($sformatf("%s_pulse_cycle", tag), 256'(cyc), 256'(last_rcv + 1));
        chk($sformatf("%s_words_issued", tag), 256'(hs), 256'(8));
        chk($sformatf("%s_req_v_done", tag), 256'(mv), 256'(1'b0));
        chk($sformatf("%s_line", tag), line, exp_line);
        got = 1'b1;
      end else begin
        chk($sformatf("%s_req_v_c%0d", tag, cyc), 256'(mv), 256'((hs < 8) && !dem));
        chk($sformatf("%s_busy_c%0d", tag, cyc), 256'(busy), 256'(1'b1));
        if (mv) chk($sformatf("%s_addr_c%0d", tag, cyc), 256'(maddr), 256'(base + 32'(4 * hs)));
      end
      pend = 1'b0;
      if (resp_v) begin rcv++; last_rcv = cyc; end
      if (mv && ready) begin hs++; pend = 1'b1; end
      @(negedge clk_i);
    end
    if (!got) chk({tag, "_pulse_timeout"}, 256'(1'b0), 256'(1'b1));
    resp_v = 1'b0; ready = 1'b0; demand = 1'b0;
    #1;
    chk({tag, "_busy_after"}, 256'(busy), 256'(1'b0));
    chk({tag, "_pulse_one_cycle"}, 256'(dv), 256'(1'b0));
    chk({tag, "_line_held"}, line, exp_line);
  endtask

  initial begin
    reset_n_i = 1'b0; req = 1'b0; addr = '0; demand = 1'b0;
    ready = 1'b0; resp_v = 1'b0; resp_data = '0;

    // rst req addr dem rdy rv data | busy v maddr dv | chk_line line
    add(0, 0, 0,        0, 0, 0, 0,      0, 0, 0,        0, 1, LINE_0);
    add(0, 0, 0,        1, 0, 0, 0,      1, 0, 0,        0, 0, LINE_0);
    add(1, 1, 'h1004,   0, 1, 0, 0,      0, 0, 0,        0, 0, LINE_0);
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 1, (i > 0), 32'hA0 + 32'(i) - 1, 1, 1, 32'h1000 + 32'(4 * i), 0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hA7,   1, 0, 0,        0, 0, LINE_0);
    add(1, 1, 'h3000,   0, 1, 0, 0,      1, 0, 0,        1, 1, LINE_A);
    add(1, 0, 0,        0, 1, 0, 0,      0, 0, 0,        0, 1, LINE_A);
    add(1, 0, 0,        0, 1, 1, 'hDEAD, 0, 0, 0,        0, 0, LINE_0);
    add(1, 1, 'h2000,   1, 1, 0, 0,      1, 0, 0,        0, 1, LINE_A);
    add(1, 0, 0,        1, 1, 0, 0,      1, 0, 0,        0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 0, 0,      0, 0, 0,        0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 0, 0,      0, 0, 0,        0, 0, LINE_0);
    add(1, 1, 'h4008,   0, 1, 0, 0,      0, 0, 0,        0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 0, 0,      1, 1, 'h4000,   0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hB0,   1, 1, 'h4004,   0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hB1,   1, 1, 'h4008,   0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hB2,   1, 1, 'h400C,   0, 0, LINE_0);
    add(0, 0, 0,        0, 1, 1, 'hB3,   0, 0, 0,        0, 1, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hB4,   0, 0, 0,        0, 0, LINE_0);
    add(1, 0, 0,        0, 1, 1, 'hB5,   0, 0, 0,        0, 1, LINE_0);
    add(1, 0, 0,        0, 1, 0, 0,      0, 0, 0,        0, 1, LINE_0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk_i);
      reset_n_i = tbl[k].rst_n; req = tbl[k].req; addr = tbl[k].addr;
      demand = tbl[k].dem; ready = tbl[k].rdy; resp_v = tbl[k].rv; resp_data = tbl[k].data;
      #1;
      chk($sformatf("vec%0d_busy", k), 256'(busy), 256'(tbl[k].busy));
      chk($sformatf("vec%0d_req_v", k), 256'(mv), 256'(tbl[k].v));
      chk($sformatf("vec%0d_req_addr", k), 256'(maddr), 256'(tbl[k].ma));
      chk($sformatf("vec%0d_line_v", k), 256'(dv), 256'(tbl[k].dv));
      if (tbl[k].chk_line) chk($sformatf("vec%0d_line", k), line, tbl[k].line);
    end
    req = 1'b0; resp_v = 1'b0; demand = 1'b0;

    run_fill("backpressure", 32'h5010, 32'h5000, 1'b1, 32'hA0, -1);
    run_fill("wrap", 32'hFFFF_FFF0, 32'hFFFF_FFE0, 1'b0, 32'hC0, -1);
`ifdef PREFETCH_DMA_RESPONDER_DEMAND_PREEMPT_EN
    run_fill("preempt", 32'h6000, 32'h6000, 1'b0, 32'hD0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prefetch_dma_responder.md
Name: prefetch_dma_responder

Overview:
- Responder end of the stream-prefetch DMA interface.
- Accepts a single prefetch line request from the stream prefetcher and breaks it into word reads on a valid/ready memory port.
- Reassembles the returned words into one full cache line, returns it with a one-cycle valid pulse, and reports busy back to the prefetcher.
- Sits between the prefetcher and the memory-side DMA arbiter, alongside the demand miss handler.

Parameters:
- addr_width_p, 32, byte address width.
- data_width_p, 32, memory word width in bits; must be a multiple of 8.
- block_size_in_words_p, 8, words per cache line; must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  reset; asynchronous assertion, active-low.
- prefetch_dma_req_i  input  1  prefetch line request strobe.
- prefetch_dma_addr_i  input  addr_width_p  requested byte address, any alignment.
- demand_busy_i  input  1  demand miss handler currently owns memory.
- dma_busy_o  output  1  busy indication to the prefetcher.
- mem_req_v_o  output  1  word read request valid.
- mem_req_addr_o  output  addr_width_p  word byte address.
- mem_req_ready_i  input  1  memory accepts the request.
- mem_resp_v_i  input  1  read data valid; responses return in order.
- mem_resp_data_i  input  data_width_p  read data.
- dma_prefetch_data_o  output  data_width_p*block_size_in_words_p  assembled line.
- dma_prefetch_data_v_o  output  1  line valid, one-cycle pulse.

Behaviour:
- Reset (reset_n_i low, asynchronous): state IDLE; all counters, base address and line buffer cleared.
  - Outputs during and after reset: mem_req_v_o=0, mem_req_addr_o=0, dma_prefetch_data_v_o=0, dma_prefetch_data_o=0.
  - dma_busy_o = demand_busy_i.
- Reset mid-fill: the line is abandoned. No pulse is produced and no later responses are captured until a new request is accepted.
- Block offset width: LOFF = log2(block_size_in_words_p * data_width_p/8).
  - Base address = prefetch_dma_addr_i with the low LOFF bits cleared.
- dma_busy_o = (state != IDLE) OR demand_busy_i. This is combinational and has no reset dependency beyond state.
- State IDLE:
  - Accepts the request when prefetch_dma_req_i=1 and demand_busy_i=0. Latches the base address, clears issue_cnt/resp_cnt, goes to FILL.
  - If demand_busy_i=1, the request is dropped silently.
  - mem_resp_v_i in IDLE is ignored.
- State FILL:
  - mem_req_v_o = (issue_cnt < block_size_in_words_p).
  - mem_req_addr_o = base + issue_cnt*(data_width_p/8), modulo 2^addr_width_p.
  - issue_cnt increments on mem_req_v_o & mem_req_ready_i.
  - mem_req_v_o and mem_req_addr_o stay stable while valid and not ready.
  - On mem_resp_v_i, the data is written to line bits [resp_cnt*data_width_p +: data_width_p] and resp_cnt increments.
  - A response may arrive in the same cycle as a request handshake; both counters update.
  - Counters are log2(block_size_in_words_p)+1 bits wide and never wrap.
  - When resp_cnt reaches block_size_in_words_p (i.e. the last response is captured), go to DONE next cycle.
  - Responses beyond block_size_in_words_p are ignored.
- State DONE:
  - dma_prefetch_data_v_o=1 for exactly one cycle.
  - dma_prefetch_data_o presents the full line and holds its value after the pulse until the next accepted request.
  - Next state is IDLE unconditionally.
- A request asserted in the DONE cycle is not accepted (busy is still high).
- Latency with zero-wait memory (ready=1, response one cycle after handshake): request accepted at cycle 0, pulse at cycle block_size_in_words_p+2.
- A new request may be accepted the cycle after DONE.

Optional Feature:
- Macro: PREFETCH_DMA_RESPONDER_DEMAND_PREEMPT_EN.
- Defined: while in FILL and demand_busy_i=1, mem_req_v_o is forced 0, so no new word requests are issued.
  - Issue resumes from the same issue_cnt once demand_busy_i=0.
  - Outstanding responses are still collected.
  - An already-asserted unaccepted request is withdrawn; this exception to handshake stability is permitted only under this macro.
- Undefined: demand_busy_i affects only IDLE acceptance and dma_busy_o; the fill proceeds regardless.

Test Plan:
- Basic fill: reset, req with addr=0x1004, ready=1, one-cycle response returning word i = 0xA0+i -> mem_req_addr_o sequence 0x1000,0x1004,...,0x101C; one-cycle v pulse; line word0=0xA0 ... word7=0xA7; busy low afterwards.
- Backpressure: ready toggling 0/1 every cycle -> each address is held stable while ready=0; exactly 8 handshakes; same assembled line.
- Drop under demand: demand_busy_i=1 with req and addr=0x2000 -> no mem_req_v_o, dma_busy_o=1; after demand drops, no activity until a new req.
- Wrap: addr=0xFFFFFFF0 (32-bit) -> base 0xFFFFFFE0; addresses 0xFFFFFFE0..0xFFFFFFFC, no overflow past the top of the address space.
- Reset mid-fill: assert reset_n_i=0 after 3 responses -> outputs 0 immediately; after release, stray responses are ignored, no pulse; a new request completes normally.
- Preempt (macro defined): demand_busy_i=1 for 5 cycles after 2 issues -> zero issues during the window; resumes at base+8; line correct.
